// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: credit-limited requests, 2-entry instruction FIFO, redirect drain.
// Define YSYX_22041412_IFU_MISALIGN_EN to halt with fetch_fault on a misaligned redirect.
module ysyx_22041412_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    output logic [63:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]  state, st_nx;
    logic [63:0] pc;
    logic [1:0]  osd, osd_nx;
    logic [1:0]  drop_cnt, drop_nx;
    logic [1:0]  fifo_cnt;
    logic [2:0]  used;
    logic        fire, pop, push, dropping;
    logic        redir_halt, drain_halt;
    logic [63:0] tgt;

    logic [63:0] aq [2];
    logic        aq_wr, aq_rd;
    logic [63:0] fq_pc [2];
    logic [31:0] fq_ins [2];
    logic        fq_wr, fq_rd;

`ifdef YSYX_22041412_IFU_MISALIGN_EN
    logic fault_q;
    assign tgt         = redirect_pc;
    assign redir_halt  = |redirect_pc[1:0];
    assign drain_halt  = fault_q;
    assign fetch_fault = fault_q;

    always_ff @(posedge clk) begin
        if (rst)
            fault_q <= 1'b0;
        else if (redirect_valid)
            fault_q <= redir_halt;
    end
`else
    assign tgt         = redirect_pc & ~64'd3;
    assign redir_halt  = 1'b0;
    assign drain_halt  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign out_valid = !rst && (fifo_cnt != 2'd0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    // A pop this cycle frees its slot, keeping one instruction per cycle.
    assign used      = {1'b0, osd} + {1'b0, fifo_cnt} - {2'b0, pop};
    assign req_valid = !rst && (state == S_RUN) && !redirect_valid
                     && (used < 3'd2);
    assign req_addr  = pc;
    assign fire      = req_valid && req_ready;

    assign dropping  = redirect_valid || (drop_cnt != 2'd0);
    assign push      = resp_valid && !dropping;
    assign osd_nx    = osd + {1'b0, fire} - {1'b0, resp_valid};

    always_comb begin
        drop_nx = drop_cnt;
        if (redirect_valid)
            drop_nx = osd_nx;
        else if (resp_valid && drop_cnt != 2'd0)
            drop_nx = drop_cnt - 2'd1;
    end

    always_comb begin
        st_nx = state;
        if (redirect_valid) begin
            if (drop_nx != 2'd0)  st_nx = S_DRAIN;
            else if (redir_halt)  st_nx = S_HALT;
            else                  st_nx = S_RUN;
        end else if (state == S_DRAIN && drop_nx == 2'd0) begin
            st_nx = drain_halt ? S_HALT : S_RUN;
        end
    end

    assign out_pc    = fq_pc[fq_rd];
    assign out_instr = fq_ins[fq_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            pc       <= RESET_PC;
            osd      <= 2'd0;
            drop_cnt <= 2'd0;
            fifo_cnt <= 2'd0;
            aq_wr    <= 1'b0;
            aq_rd    <= 1'b0;
            fq_wr    <= 1'b0;
            fq_rd    <= 1'b0;
        end else begin
            state    <= st_nx;
            osd      <= osd_nx;
            drop_cnt <= drop_nx;
            if (redirect_valid)
                pc <= tgt;
            else if (fire)
                pc <= pc + 64'd4;
            if (fire)
                aq_wr <= ~aq_wr;
            if (resp_valid)
                aq_rd <= ~aq_rd;
            if (redirect_valid) begin
                fifo_cnt <= 2'd0;
                fq_rd    <= fq_wr;
            end else begin
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
                if (push)
                    fq_wr <= ~fq_wr;
                if (pop)
                    fq_rd <= ~fq_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            aq[aq_wr] <= pc;
        if (push) begin
            fq_pc[fq_wr]  <= aq[aq_rd];
            fq_ins[fq_wr] <= resp_data;
        end
    end

endmodule
